// File: rtl/pong_pkg.sv
// Shared types for the ping-pong match controller: FSM states, winner and serve-side encodings.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        RALLY,
        POINT,
        OVER
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse when the level goes 0 -> 1.
module pong_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= i_level;
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencing FSM: start, serve, rally, point, game over. Define AUTO_SERVE_EN to launch
// serves automatically once the serve delay elapses instead of waiting for a serve_btn edge.
//
// state      | meaning
// IDLE       | opening screen, waiting for start
// SERVE_WAIT | serve delay running, then waiting for serve
// RALLY      | ball in play, watching miss events
// POINT      | field frozen after a point
// OVER       | match finished, scores and winner frozen
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 3,
    parameter int SERVE_DELAY = 25_000_000,
    parameter int POINT_HOLD  = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               serve_btn,
    input  logic               miss1,
    input  logic               miss2,
    output logic               start_o,
    output logic               reset_game,
    output logic               serve_go,
    output logic               serve_side,
    output logic [SCORE_W-1:0] sc1,
    output logic [SCORE_W-1:0] sc2,
    output logic [1:0]         winner,
    output logic               game_over
);

    localparam int                 CNT_W    = $clog2(max_int(SERVE_DELAY, POINT_HOLD) + 1);
    localparam logic [CNT_W-1:0]   L_SD_M1  = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0]   L_PH_M1  = CNT_W'(POINT_HOLD - 1);
    localparam logic [SCORE_W-1:0] L_WIN_M1 = SCORE_W'(WIN_SCORE - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SCORE_W-1:0] r_sc1, r_sc2, w_sc1_nxt, w_sc2_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic               r_side, w_side_nxt;
    logic               r_reset_game, w_reset_game_nxt;
    logic               r_serve_go, w_serve_go_nxt;
    logic               r_start_o, r_game_over;
    logic               w_start_edge, w_serve_edge, w_armed, w_serve_evt;

    pong_edge_detect u_start_edge (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (start),
        .o_rise  (w_start_edge)
    );

    pong_edge_detect u_serve_edge (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (serve_btn),
        .o_rise  (w_serve_edge)
    );

    // Counter saturates at SERVE_DELAY-1, so the serve stays armed until it fires.
    assign w_armed = (r_cnt == L_SD_M1);

`ifdef AUTO_SERVE_EN
    logic w_unused_serve;
    assign w_unused_serve = w_serve_edge;
    assign w_serve_evt    = w_armed;
`else
    assign w_serve_evt    = w_armed & w_serve_edge;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sc1        <= '0;
            r_sc2        <= '0;
            r_winner     <= WIN_NONE;
            r_side       <= SIDE_P1;
            r_reset_game <= 1'b0;
            r_serve_go   <= 1'b0;
            r_start_o    <= 1'b1;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sc1        <= w_sc1_nxt;
            r_sc2        <= w_sc2_nxt;
            r_winner     <= w_winner_nxt;
            r_side       <= w_side_nxt;
            r_reset_game <= w_reset_game_nxt;
            r_serve_go   <= w_serve_go_nxt;
            r_start_o    <= (w_state_nxt == IDLE);
            r_game_over  <= (w_state_nxt == OVER);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, OVER: begin
                if (w_start_edge) begin
                    w_state_nxt = SERVE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            SERVE_WAIT: begin
                if (w_serve_evt) begin
                    w_state_nxt = RALLY;
                    w_cnt_nxt   = '0;
                end else if (!w_armed) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RALLY: begin
                w_cnt_nxt = '0;
                if (miss1 && miss2)  w_state_nxt = SERVE_WAIT;
                else if (miss2)      w_state_nxt = (r_sc1 == L_WIN_M1) ? OVER : POINT;
                else if (miss1)      w_state_nxt = (r_sc2 == L_WIN_M1) ? OVER : POINT;
            end
            POINT: begin
                if (r_cnt == L_PH_M1) begin
                    w_state_nxt = SERVE_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_sc1_nxt        = r_sc1;
        w_sc2_nxt        = r_sc2;
        w_winner_nxt     = r_winner;
        w_side_nxt       = r_side;
        w_reset_game_nxt = 1'b0;
        w_serve_go_nxt   = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (w_start_edge) begin
                    w_sc1_nxt        = '0;
                    w_sc2_nxt        = '0;
                    w_winner_nxt     = WIN_NONE;
                    w_side_nxt       = SIDE_P1;
                    w_reset_game_nxt = 1'b1;
                end
            end
            SERVE_WAIT: w_serve_go_nxt = w_serve_evt;
            RALLY: begin
                // Simultaneous misses replay the point from the same side.
                if (miss1 && miss2) begin
                    w_reset_game_nxt = 1'b1;
                end else if (miss2) begin
                    w_sc1_nxt = r_sc1 + 1'b1;
                    if (r_sc1 == L_WIN_M1) w_winner_nxt = WIN_P1;
                    else                   w_side_nxt   = SIDE_P2;
                end else if (miss1) begin
                    w_sc2_nxt = r_sc2 + 1'b1;
                    if (r_sc2 == L_WIN_M1) w_winner_nxt = WIN_P2;
                    else                   w_side_nxt   = SIDE_P1;
                end
            end
            POINT: w_reset_game_nxt = (r_cnt == L_PH_M1);
            default: ;
        endcase
    end

    assign start_o    = r_start_o;
    assign reset_game = r_reset_game;
    assign serve_go   = r_serve_go;
    assign serve_side = r_side;
    assign sc1        = r_sc1;
    assign sc2        = r_sc2;
    assign winner     = r_winner;
    assign game_over  = r_game_over;

endmodule
